// File: rtl/mult_row_sequencer.sv
// ============================================================================
//  Module      : mult_row_sequencer
//  Description : Iterative unsigned multiplier that reuses one partial-product
//                row over WIDTH cycles, with valid/ready operand and result
//                handshakes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_row_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_valid,
    output logic                       start_ready,
    input  logic [WIDTH-1:0]           multiplicand,
    input  logic [WIDTH-1:0]           multiplier,
    output logic [2*WIDTH-1:0]         result,
    output logic                       result_valid,
    input  logic                       result_ready,
    output logic                       busy,
    output logic [$clog2(WIDTH)-1:0]   row_idx
);

    localparam int                  c_idx_w    = $clog2(WIDTH);
    localparam logic [c_idx_w-1:0]  c_last_row = c_idx_w'(WIDTH - 1);

    if (WIDTH < 2 || WIDTH > 16) begin : g_width_check
        $error("mult_row_sequencer: WIDTH must be within 2..16");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [WIDTH-1:0]       r_mcand;
    logic [WIDTH-1:0]       r_mplier;
    logic [2*WIDTH-1:0]     r_acc;

    logic [WIDTH-1:0]       w_row_bits;
    logic [2*WIDTH-1:0]     w_row_shifted;
    logic [2*WIDTH-1:0]     w_acc_next;

    // One AND row gated by the selected multiplier bit, aligned to its weight.
    assign w_row_bits    = r_mcand & {WIDTH{r_mplier[row_idx]}};
    assign w_row_shifted = {{WIDTH{1'b0}}, w_row_bits} << row_idx;
    assign w_acc_next    = r_acc + w_row_shifted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_mcand      <= '0;
            r_mplier     <= '0;
            r_acc        <= '0;
            row_idx      <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            start_ready  <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_valid) begin
                        r_mcand     <= multiplicand;
                        r_mplier    <= multiplier;
                        r_acc       <= '0;
                        row_idx     <= '0;
                        start_ready <= 1'b0;
                        busy        <= 1'b1;
                        r_state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_next;
                    // Every row is visited, even zero rows, so latency is fixed.
                    if (row_idx == c_last_row) begin
                        result       <= w_acc_next;
                        result_valid <= 1'b1;
                        r_state      <= S_DONE;
                    end else begin
                        row_idx <= row_idx + c_idx_w'(1);
                    end
                end
                S_DONE: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        busy         <= 1'b0;
                        start_ready  <= 1'b1;
                        row_idx      <= '0;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    result_valid <= 1'b0;
                    busy         <= 1'b0;
                    start_ready  <= 1'b1;
                    row_idx      <= '0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mult_row_sequencer.sv
// ============================================================================
//  Module      : tb_mult_row_sequencer
//  Description : Scoreboard bench for mult_row_sequencer at WIDTH=4 and 8.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_row_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        sv4 = 1'b0, sr4, rv4, rr4 = 1'b1, busy4;
    logic [3:0]  a4 = '0, b4 = '0;
    logic [7:0]  res4;
    logic [1:0]  ridx4;

    logic        sv8 = 1'b0, sr8, rv8, rr8 = 1'b1, busy8;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] res8;
    logic [2:0]  ridx8;

    mult_row_sequencer #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start_valid(sv4), .start_ready(sr4),
        .multiplicand(a4), .multiplier(b4), .result(res4), .result_valid(rv4),
        .result_ready(rr4), .busy(busy4), .row_idx(ridx4)
    );

    mult_row_sequencer #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start_valid(sv8), .start_ready(sr8),
        .multiplicand(a8), .multiplier(b8), .result(res8), .result_valid(rv8),
        .result_ready(rr8), .busy(busy8), .row_idx(ridx8)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint prod;
        int     acc;
    } exp_t;

    exp_t   q0[$];
    exp_t   q1[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    bit     hs4 = 1'b0, hs8 = 1'b0;
    bit     pv[2] = '{1'b0, 1'b0};
    longint held[2] = '{0, 0};
    bit     rr_rand = 1'b0;

    task automatic check(string name, int u, longint act, longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s unit%0d at cycle %0d: got %0d expected %0d", name, u, cyc, act, expv);
        end
    endtask

    task automatic fail_now(string name, int u);
        checks++;
        errors++;
        $display("FAIL %s unit%0d at cycle %0d: bound expired", name, u, cyc);
    endtask

    function automatic int qsize(int u);
        if (u == 0) return q0.size();
        return q1.size();
    endfunction

    function automatic exp_t qfront(int u);
        if (u == 0) return q0[0];
        return q1[0];
    endfunction

    function automatic exp_t qpop(int u);
        if (u == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    // Handshake inputs as actually seen by the DUT at the rising edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        hs4 <= rr4;
        hs8 <= rr8;
    end

    task automatic mon(int u, int w, bit rv, longint res, int ridx, bit bsy, bit sr, bit hs);
        exp_t e;
        if (rv && !pv[u]) begin
            if (qsize(u) == 0) begin
                fail_now("unexpected_result", u);
            end else begin
                e = qpop(u);
                check("product", u, res, e.prod);
                check("latency", u, cyc - e.acc, w);
                check("row_idx_done", u, ridx, w - 1);
                held[u] = e.prod;
            end
        end else if (pv[u]) begin
            if (hs) begin
                check("valid_drop", u, rv, 0);
            end else begin
                check("valid_hold", u, rv, 1);
                check("result_hold", u, res, held[u]);
            end
        end
        if (bsy && !rv) begin
            check("start_ready_run", u, sr, 0);
            if (qsize(u) != 0) check("row_idx_run", u, ridx, cyc - qfront(u).acc);
        end
        if (bsy && rv) check("start_ready_done", u, sr, 0);
        if (!bsy) begin
            check("start_ready_idle", u, sr, 1);
            check("result_keep_idle", u, res, held[u]);
        end
        pv[u] = rv;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, 4, rv4, longint'(res4), int'(ridx4), busy4, sr4, hs4);
            mon(1, 8, rv8, longint'(res8), int'(ridx8), busy8, sr8, hs8);
        end else begin
            pv[0] = 1'b0;  pv[1] = 1'b0;
            held[0] = 0;   held[1] = 0;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rr_rand) begin
                rr4 = 1'($urandom_range(0, 1));
                rr8 = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic issue(int u, int a, int b, bit keep);
        int   guard = 0;
        exp_t e;
        @(negedge clk);
        if (u == 0) begin sv4 = 1'b1; a4 = a[3:0]; b4 = b[3:0]; end
        else        begin sv8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; end
        while (((u == 0) ? sr4 : sr8) !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            fail_now("accept_timeout", u);
            if (u == 0) sv4 = 1'b0; else sv8 = 1'b0;
            return;
        end
        e.prod = longint'(a) * longint'(b);
        e.acc  = cyc + 1;
        if (u == 0) q0.push_back(e); else q1.push_back(e);
        @(negedge clk);
        if (u == 0) begin
            a4 = 4'($urandom_range(0, 15)); b4 = 4'($urandom_range(0, 15));
            if (!keep) sv4 = 1'b0;
        end else begin
            a8 = 8'($urandom_range(0, 255)); b8 = 8'($urandom_range(0, 255));
            if (!keep) sv8 = 1'b0;
        end
    endtask

    task automatic drain();
        int g = 0;
        while ((qsize(0) != 0 || qsize(1) != 0 || busy4 || busy8) && g < 400) begin
            @(negedge clk);
            g++;
        end
        if (g >= 400) fail_now("drain_timeout", 0);
    endtask

    initial begin
        int g;
        repeat (2) @(negedge clk);
        check("reset_start_ready", 0, sr4, 1);
        check("reset_busy", 0, busy4, 0);
        check("reset_valid", 0, rv4, 0);
        check("reset_result", 0, res4, 0);
        check("reset_row_idx", 0, ridx4, 0);
        check("reset_start_ready", 1, sr8, 1);
        check("reset_result", 1, res8, 0);
        #2 rst_n = 1'b1;

        issue(0, 13, 11, 0);
        issue(0, 15, 15, 0);
        issue(0, 0, 9, 0);
        issue(0, 9, 0, 0);
        issue(1, 255, 255, 0);
        drain();

        // Backpressure with start_valid held high throughout.
        rr4 = 1'b0;
        issue(0, 6, 7, 1);
        a4 = 4'd1; b4 = 4'd1;
        g = 0;
        while (rv4 !== 1'b1 && g < 20) begin @(negedge clk); g++; end
        if (g >= 20) fail_now("backpressure_wait", 0);
        repeat (5) @(negedge clk);
        rr4 = 1'b1;
        issue(0, 1, 1, 0);
        drain();

        // Operands changing after accept must be ignored.
        issue(0, 5, 3, 0);
        a4 = 4'd15; b4 = 4'd15;
        drain();

        // Asynchronous reset in the middle of a run.
        issue(0, 5, 9, 0);
        g = 0;
        while (ridx4 != 2'd2 && g < 20) begin @(negedge clk); g++; end
        if (g >= 20) fail_now("row2_wait", 0);
        #2 rst_n = 1'b0;
        #1;
        check("async_start_ready", 0, sr4, 1);
        check("async_result", 0, res4, 0);
        check("async_valid", 0, rv4, 0);
        check("async_busy", 0, busy4, 0);
        check("async_row_idx", 0, ridx4, 0);
        q0.delete();
        q1.delete();
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        issue(0, 2, 3, 0);
        drain();

        rr_rand = 1'b1;
        fork
            begin
                for (int i = 0; i < 25; i++)
                    issue(0, $urandom_range(0, 15), $urandom_range(0, 15),
                          (i < 24) ? 1'($urandom_range(0, 1)) : 1'b0);
            end
            begin
                issue(1, 255, 255, 0);
                for (int j = 0; j < 10; j++)
                    issue(1, $urandom_range(0, 255), $urandom_range(0, 255),
                          (j < 9) ? 1'($urandom_range(0, 1)) : 1'b0);
            end
        join
        rr_rand = 1'b0;
        rr4 = 1'b1;
        rr8 = 1'b1;
        drain();
        check("queue_empty", 0, qsize(0), 0);
        check("queue_empty", 1, qsize(1), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
        $fatal(1);
    end

endmodule

`default_nettype wire
